// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input combination of an N-input boolean
// function in ascending order, streams each row over a valid/ready handshake
// and collects the results into a ROWS-bit table vector.
module truth_table_sweeper #(
  parameter  int N    = 2,
  localparam int ROWS = 2**N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_row,
  output logic            out_s,
  output logic [ROWS-1:0] table_vec,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // The counter is one bit wider than the row index so the last row is
  // distinguishable from a wrapped counter.
  localparam logic [N:0] LAST_ROW = (N+1)'(ROWS - 1);
  localparam logic [N:0] ONE      = (N+1)'(1);

  state_t            r_state;
  state_t            w_next;
  logic [N:0]        r_cnt;
  logic [2:0]        r_func;
  logic [ROWS-1:0]   r_table;
  logic [N-1:0]      w_x;
  logic              w_a;
  logic              w_b;
  logic              w_s;
  logic              w_xfer;

  assign w_x    = r_cnt[N-1:0];
  assign w_a    = w_x[N-1];
  assign w_b    = w_x[0];
  assign w_xfer = (r_state == S_RUN) && out_ready && !abort;

  // Evaluate the latched function on the current row.
  always_comb begin
    w_s = 1'b0;
    case (r_func)
      3'd0:    w_s = &w_x;
      3'd1:    w_s = |w_x;
      3'd2:    w_s = ^w_x;
      3'd3:    w_s = ~^w_x;
      3'd4:    w_s = ~&w_x;
      3'd5:    w_s = ~|w_x;
      3'd6:    w_s = ~w_a & w_b;
      default: w_s = w_a | ~w_b;
    endcase
  end

  // Next-state and handshake-facing outputs; abort takes priority over a
  // row transfer, and row outputs are forced to zero outside RUN.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    out_row   = '0;
    out_s     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_row   = w_x;
        out_s     = w_s;
        if (abort)
          w_next = S_IDLE;
        else if (out_ready && (r_cnt == LAST_ROW))
          w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Row counter, latched function and result table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_func  <= 3'd0;
      r_table <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_cnt   <= '0;
      r_func  <= func;
      r_table <= '0;
    end else if (w_xfer) begin
      r_table[w_x] <= w_s;
      if (r_cnt != LAST_ROW) r_cnt <= r_cnt + ONE;
    end
  end

  assign table_vec = r_table;

endmodule
